// File: rtl/mul_seq32_pkg.sv
// Shared definitions for the sequential shift-add multiplier: widths,
// iteration count and controller state encoding.
package mul_seq32_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = 6;
  localparam int MUL_ITERS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : mul_seq32_pkg

// File: rtl/FA_32dataflow.sv
// 32-bit dataflow adder; Cin=1 turns it into In1 - In2 (two's complement).
module FA_32dataflow (
  input  logic [31:0] In1,
  input  logic [31:0] In2,
  input  logic        Cin,
  output logic [31:0] Sum,
  output logic        Cout
);

  logic [31:0] in2_eff;

  assign in2_eff     = In2 ^ {32{Cin}};
  assign {Cout, Sum} = {1'b0, In1} + {1'b0, in2_eff} + {32'd0, Cin};

endmodule : FA_32dataflow

// File: rtl/mul_seq32.sv
// Sequential 32x32 -> 64 unsigned shift-add multiplier: one adder pass per
// cycle over 32 cycles, with a start/busy/done handshake and a held product.
module mul_seq32
  import mul_seq32_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     mq_q, mq_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     add_in2;
  logic [WIDTH-1:0]     add_sum;
  logic                 add_cout;
  logic [2*WIDTH-1:0]   shifted;

  assign add_in2 = mq_q[0] ? mcand_q : '0;

  FA_32dataflow u_adder (
    .In1  (acc_q),
    .In2  (add_in2),
    .Cin  (1'b0),
    .Sum  (add_sum),
    .Cout (add_cout)
  );

  // Cout must land in the top bit, otherwise large operands lose their MSB.
  assign shifted = {add_cout, add_sum, mq_q[WIDTH-1:1]};

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE lasts exactly one cycle; accepting start on its exit edge
        // gives the 33-cycle issue interval without disturbing the result.
        if (start) begin
          mcand_d = a;
          acc_d   = '0;
          mq_d    = b;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        {acc_d, mq_d} = shifted;
        cnt_d         = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MUL_ITERS - 1)) begin
          state_d   = ST_DONE;
          product_d = shifted;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule : mul_seq32

// File: tb/tb_mul_seq32.sv
// Scoreboard bench for mul_seq32: the driver queues expected products and
// done cycles, a negedge monitor checks every done pulse against the queue.
module tb_mul_seq32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] product;

  mul_seq32 dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] prod;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   busy_run = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    return {32'd0, x} * {32'd0, y};
  endfunction

  // Monitor: exclusivity every cycle, busy-run length and result on each done.
  always @(negedge clk) begin
    if (reset) begin
      busy_run = 0;
    end else begin
      check("busy_done_exclusive", {63'd0, busy & done}, 64'd0);
      if (busy) begin
        busy_run++;
      end else if (done) begin
        check("done_expected", {63'd0, sb.size() != 0}, 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("product", product, e.prod);
          check("done_cycle", 64'(cyc), 64'(e.done_cyc));
          check("busy_cycles", 64'(busy_run), 64'd32);
        end
        busy_run = 0;
      end else begin
        busy_run = 0;
      end
    end
  end

  task automatic issue(input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    e.prod = ref_mul(x, y);
    e.done_cyc = cyc + 32;
    sb.push_back(e);
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk); #1;
    end
    check(name, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] vec_a [4];
    logic [31:0] vec_b [4];
    vec_a[0] = 32'hFFFFFFFF; vec_b[0] = 32'hFFFFFFFF;
    vec_a[1] = 32'h0;        vec_b[1] = 32'h12345678;
    vec_a[2] = 32'h89ABCDEF; vec_b[2] = 32'h1;
    vec_a[3] = 32'h80000000; vec_b[3] = 32'h80000001;

    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_product", product, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Basic multiply and hold.
    issue(32'd3, 32'd5);
    drain("basic_drain");
    repeat (10) @(negedge clk);
    #1;
    check("product_held", product, 64'd15);

    // Boundary operands.
    for (int i = 0; i < 4; i++) begin
      issue(vec_a[i], vec_b[i]);
      drain("vector_drain");
    end

    // Random operands.
    for (int i = 0; i < 6; i++) begin
      issue($urandom, $urandom);
      drain("random_drain");
    end

    // Start pulsed mid-RUN must be ignored.
    issue(32'd7, 32'd6);
    repeat (9) @(posedge clk);
    @(negedge clk);
    a = 32'd9; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("ignored_start_drain");
    repeat (40) @(negedge clk);
    #1;
    check("ignored_start_product", product, 64'd42);

    // Reset in the middle of RUN discards the operation.
    issue($urandom | 32'h1, $urandom | 32'h1);
    repeat (14) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_busy", {63'd0, busy}, 64'd0);
    check("midreset_done", {63'd0, done}, 64'd0);
    check("midreset_product", product, 64'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    issue(32'd2, 32'd4);
    drain("post_reset_drain");

    // Back-to-back issue with start held high.
    begin
      exp_t e;
      int   c0;
      @(negedge clk);
      a = 32'd10; b = 32'd10; start = 1'b1;
      @(posedge clk); #1;
      c0 = cyc;
      for (int k = 0; k < 3; k++) begin
        e.prod = 64'd100;
        e.done_cyc = c0 + 32 + 33 * k;
        sb.push_back(e);
      end
      repeat (66) @(posedge clk);
      #1;
      start = 1'b0;
      drain("b2b_drain");
      repeat (40) @(negedge clk);
    end

    check("final_queue_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_mul_seq32
